// File: rtl/multi_mode_counter.sv
// multi_mode_counter: loadable up/down counter that wraps silently, priority reset > load > count
module multi_mode_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             upDown,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge clk)
    r_count <= reset ? '0 : load ? loadValue : upDown ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
  assign count = r_count;
endmodule

// File: tb/tb_multi_mode_counter.sv
// tb_multi_mode_counter: scoreboard bench with directed vectors and a random phase
module tb_multi_mode_counter;
  logic clk = 0;
  logic reset = 1;
  logic load = 0;
  logic upDown = 0;
  logic [3:0] loadValue = 0;
  logic [3:0] count;
  logic [3:0] exp_q[$];
  logic [3:0] m;
  int errors = 0;
  int checks = 0;
  multi_mode_counter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .upDown(upDown),
    .loadValue(loadValue), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: count=%b expected=%b", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic l, input logic u,
                      input logic [3:0] lv, input logic [3:0] want);
    @(negedge clk);
    reset = r;
    load = l;
    upDown = u;
    loadValue = lv;
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else check(tag, count, exp_q.pop_front());
  endtask
  initial begin
    for (int i = 0; i < 5; i++) step("reset_hold", 1, 0, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) step("load_1010", 0, 1, 0, 4'b1010, 4'b1010);
    step("up", 0, 0, 1, 4'b0000, 4'b1011);
    step("up", 0, 0, 1, 4'b0000, 4'b1100);
    step("up", 0, 0, 1, 4'b0000, 4'b1101);
    step("up", 0, 0, 1, 4'b0000, 4'b1110);
    step("up", 0, 0, 1, 4'b0000, 4'b1111);
    step("up_wrap", 0, 0, 1, 4'b0000, 4'b0000);
    step("up_after_wrap", 0, 0, 1, 4'b0000, 4'b0001);
    step("dir_change", 0, 0, 0, 4'b0000, 4'b0000);
    step("down_wrap", 0, 0, 0, 4'b0000, 4'b1111);
    step("down", 0, 0, 0, 4'b0000, 4'b1110);
    step("down", 0, 0, 0, 4'b0000, 4'b1101);
    step("down", 0, 0, 0, 4'b0000, 4'b1100);
    step("down", 0, 0, 0, 4'b0000, 4'b1011);
    step("down", 0, 0, 0, 4'b0000, 4'b1010);
    for (int i = 0; i < 3; i++) step("load_0011_up", 0, 1, 1, 4'b0011, 4'b0011);
    step("first_after_load", 0, 0, 1, 4'b0000, 4'b0100);
    step("up_after_load", 0, 0, 1, 4'b0000, 4'b0101);
    step("up_after_load", 0, 0, 1, 4'b0000, 4'b0110);
    step("load_track", 0, 1, 0, 4'b1001, 4'b1001);
    step("load_track", 0, 1, 0, 4'b0010, 4'b0010);
    step("reset_over_load", 1, 1, 1, 4'b1111, 4'b0000);
    step("resume_up", 0, 0, 1, 4'b0000, 4'b0001);
    step("resume_up", 0, 0, 1, 4'b0000, 4'b0010);
    step("reset_mid_count", 1, 0, 1, 4'b0111, 4'b0000);
    step("resume_down", 0, 0, 0, 4'b0000, 4'b1111);
    m = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      logic r, l, u;
      logic [3:0] lv;
      r = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 4) == 0);
      u = 1'($urandom_range(0, 1));
      lv = 4'($urandom_range(0, 15));
      if (r) m = 4'b0000;
      else if (l) m = lv;
      else if (u) m = m + 4'd1;
      else m = m - 4'd1;
      step("random", r, l, u, lv, m);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 4, giving the counter and load-value width in bits; WIDTH SHALL be >= 2.
- REQ-002: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
- REQ-003: Port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004: Port load, input, 1 bit: synchronous parallel-load request, active-high.
- REQ-005: Port upDown, input, 1 bit: count direction; 1 = up, 0 = down.
- REQ-006: Port loadValue, input, WIDTH bits: value captured when load is asserted.
- REQ-007: Port count, output, WIDTH bits: current counter value, driven directly from a register with no combinational path from any input.

Function
- REQ-008: The block SHALL evaluate its inputs at every rising edge of clk with fixed priority reset > load > count.
- REQ-009: With reset=1, count SHALL become 0 at the edge, regardless of load, upDown and loadValue.
- REQ-010: With reset=0 and load=1, count SHALL become loadValue at the edge, with a latency of one edge.
- REQ-011: While load stays 1, count SHALL track loadValue each cycle and SHALL NOT count.
- REQ-012: With reset=0, load=0 and upDown=1, count SHALL become count+1 modulo 2^WIDTH at each edge.
- REQ-013: With reset=0, load=0 and upDown=0, count SHALL become count-1 modulo 2^WIDTH at each edge.
- REQ-014: The counter SHALL run every cycle it is neither reset nor loaded; there is no separate enable and no hold mode.
- REQ-015: Wrap-around SHALL be silent: 2^WIDTH-1 + 1 -> 0 and 0 - 1 -> 2^WIDTH-1, with no flag and no saturation.
- REQ-016: A change of upDown SHALL take effect at the next edge, with no idle cycle; the step at that edge uses the new direction.
- REQ-017: The first count step after load deasserts SHALL start from the loaded value.
- REQ-018: All arithmetic SHALL be unsigned WIDTH-bit; loadValue SHALL be used as-is with no extension or truncation.

Reset
- REQ-019: count SHALL be 0 at the first edge with reset=1 and SHALL remain 0 for every edge reset stays high.
- REQ-020: Before the first reset edge, count is undefined; the block SHALL require no asynchronous initialization.
- REQ-021: Reset asserted mid-count or mid-load SHALL override at that edge.
- REQ-022: After reset deasserts, behaviour SHALL resume per REQ-010 to REQ-013 at the next edge.

Verification
- REQ-023: reset=1 for 5 cycles with upDown=0 and load=0 -> count = 0000 throughout; no decrement.
- REQ-024: reset=0, load=1, loadValue=1010 for 5 cycles -> count = 1010 after the first edge and held.
- REQ-025: From 1010, load=0, upDown=1 for 5 cycles -> 1011, 1100, 1101, 1110, 1111; the next up edge -> 0000 (wrap).
- REQ-026: From 1111, upDown=0 for 5 cycles -> 1110, 1101, 1100, 1011, 1010; from 0000, one down edge -> 1111 (wrap).
- REQ-027: load=1, loadValue=0011 with upDown=1 -> count = 0011 held; after load=0 -> 0100, 0101, 0110, ... each edge.
- REQ-028: reset=1 and load=1 with loadValue=1111 at the same edge -> count = 0000; reset asserted while counting -> 0000 at that edge.
